// File: rtl/dm_ctrl_pkg.sv
// Shared encodings for the data-memory access controller:
// FSM states, requester ids and the fixed D-port byte-enable mask.
package dm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic OWN_M = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/dm_arb_pick.sv
// Grant decision between the M stage and the debug/DMA port, with a
// starvation counter that forces D through after STARVE_MAX M grants.
module dm_arb_pick
    import dm_ctrl_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic in_idle,
    input  logic m_req,
    input  logic d_req,
    output logic grant_valid,
    output logic grant_owner
);

    logic [3:0] starve_q, starve_d;

    always_comb begin
        grant_valid = in_idle & (m_req | d_req);
        grant_owner = (d_req && (!m_req || starve_q == 4'(STARVE_MAX))) ? OWN_D : OWN_M;

        starve_d = starve_q;
        if (in_idle) begin
            // No waiting D or a D grant both reset the fairness window.
            if (!d_req || grant_owner == OWN_D) begin
                starve_d = '0;
            end else if (starve_q != 4'(STARVE_MAX)) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// Sequences single-port data-memory accesses for the M stage and a debug/DMA
// port, turning the fixed MEM_LAT read latency into a request/done handshake.
module dm_access_ctrl
    import dm_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_req,
    input  logic        m_we,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    input  logic [3:0]  m_be,
    output logic        m_stall,
    output logic        m_done,
    output logic [31:0] m_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata
);

    state_e      state_q, state_d;
    logic        own_q, own_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] m_rdata_q, m_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        grant_valid, grant_owner;

    dm_arb_pick #(
        .STARVE_MAX(STARVE_MAX)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .in_idle    (state_q == IDLE),
        .m_req      (m_req),
        .d_req      (d_req),
        .grant_valid(grant_valid),
        .grant_owner(grant_owner)
    );

    always_comb begin
        state_d   = state_q;
        own_d     = own_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        cnt_d     = cnt_q;
        m_rdata_d = m_rdata_q;
        d_rdata_d = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    own_d = grant_owner;
                    if (grant_owner == OWN_D) begin
                        we_d    = d_we;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        be_d    = BE_FULL;
                    end else begin
                        we_d    = m_we;
                        addr_d  = m_addr;
                        wdata_d = m_wdata;
                        be_d    = m_be;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = 4'(MEM_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // cnt_q==1 is exactly MEM_LAT cycles after the command cycle.
                if (cnt_q == 4'd1) begin
                    if (!we_q) begin
                        if (own_q == OWN_D) d_rdata_d = mem_rdata;
                        else                m_rdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            own_q     <= OWN_M;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            cnt_q     <= '0;
            m_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            own_q     <= own_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            cnt_q     <= cnt_d;
            m_rdata_q <= m_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign mem_en    = (state_q == ISSUE);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;

    assign m_done  = (state_q == RESP) && (own_q == OWN_M);
    assign d_done  = (state_q == RESP) && (own_q == OWN_D);
    assign m_rdata = m_rdata_q;
    assign d_rdata = d_rdata_q;
    assign m_stall = m_req & ~m_done;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed, scoreboard-based bench for dm_access_ctrl (MEM_LAT=2 and MEM_LAT=1
// instances), each with a byte-enabled memory model of fixed read latency.
module tb_dm_access_ctrl;

    localparam int unsigned LAT0 = 2;
    localparam int unsigned SMAX = 4;
    localparam int unsigned LAT1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        m_req, m_we, m_stall, m_done;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_be;
    logic        d_req, d_we, d_done;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    logic        m1_req, m1_we, m1_stall, m1_done;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_be;
    logic        d1_req, d1_we, d1_done;
    logic [31:0] d1_addr, d1_wdata, d1_rdata;
    logic        mem1_en, mem1_we;
    logic [31:0] mem1_addr, mem1_wdata, mem1_rdata;
    logic [3:0]  mem1_be;

    dm_access_ctrl #(.MEM_LAT(LAT0), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_stall(m_stall), .m_done(m_done), .m_rdata(m_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    dm_access_ctrl #(.MEM_LAT(LAT1), .STARVE_MAX(SMAX)) dut1 (
        .clk(clk), .reset(reset),
        .m_req(m1_req), .m_we(m1_we), .m_addr(m1_addr), .m_wdata(m1_wdata), .m_be(m1_be),
        .m_stall(m1_stall), .m_done(m1_done), .m_rdata(m1_rdata),
        .d_req(d1_req), .d_we(d1_we), .d_addr(d1_addr), .d_wdata(d1_wdata),
        .d_done(d1_done), .d_rdata(d1_rdata),
        .mem_en(mem1_en), .mem_we(mem1_we), .mem_addr(mem1_addr), .mem_wdata(mem1_wdata),
        .mem_be(mem1_be), .mem_rdata(mem1_rdata)
    );

    // Memory models: word array, byte-enabled writes, read data MEM_LAT after command.
    logic [31:0] mem0 [0:255];
    logic [31:0] mem1 [0:255];
    logic [31:0] rp0, rp1, rq0;

    always @(posedge clk) begin
        if (mem_en && mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem0[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        if (mem_en) rp0 <= mem0[mem_addr[9:2]];
        rp1 <= rp0;
    end
    assign mem_rdata = rp1;

    always @(posedge clk) begin
        if (mem1_en && mem1_we)
            for (int b = 0; b < 4; b++)
                if (mem1_be[b]) mem1[mem1_addr[9:2]][8*b +: 8] <= mem1_wdata[8*b +: 8];
        if (mem1_en) rq0 <= mem1[mem1_addr[9:2]];
    end
    assign mem1_rdata = rq0;

    int unsigned vecs = 0;
    int unsigned errs = 0;
    logic [32:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access on the MEM_LAT=2 instance, started in an IDLE cycle.
    task automatic xact(input logic is_d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rd, input string tag);
        int          lat;
        logic        got;
        logic [32:0] e;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata; m_be = be;
        end
        sb_q.push_back({is_d, exp_rd});
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            #1;
            check({tag, " mem_en"}, 32'(mem_en), 32'(lat == 1));
            if (!is_d) check({tag, " m_stall"}, 32'(m_stall), 32'(lat < int'(LAT0 + 2)));
            if (lat == 1) begin
                check({tag, " mem_addr"}, mem_addr, addr);
                check({tag, " mem_we"}, 32'(mem_we), 32'(we));
                check({tag, " mem_be"}, 32'(mem_be), is_d ? 32'hF : 32'(be));
            end
            if (m_done || d_done) begin
                got = 1'b1;
                e = sb_q.pop_front();
                check({tag, " owner"}, 32'(d_done), 32'(e[32]));
                check({tag, " latency"}, 32'(lat), LAT0 + 2);
                check({tag, " rdata"}, is_d ? d_rdata : m_rdata, e[31:0]);
            end
            tick();
            lat++;
        end
        check({tag, " done seen"}, 32'(got), 32'd1);
        if (is_d) d_req = 1'b0;
        else      m_req = 1'b0;
    endtask

    // D access on the MEM_LAT=1 instance.
    task automatic xact1(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input string tag);
        int   lat;
        logic got;
        d1_req = 1'b1; d1_we = we; d1_addr = addr; d1_wdata = wdata;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            #1;
            if (d1_done) begin
                got = 1'b1;
                check({tag, " latency"}, 32'(lat), LAT1 + 2);
                check({tag, " rdata"}, d1_rdata, exp_rd);
            end
            tick();
            lat++;
        end
        check({tag, " done seen"}, 32'(got), 32'd1);
        d1_req = 1'b0;
    endtask

    initial begin : main
        int          n, c;
        logic [32:0] e;

        for (int i = 0; i < 256; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        mem0[4] = 32'h1234_5678;

        reset = 1'b1;
        m_req = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
        d1_req = 0; d1_we = 0; d1_addr = '0; d1_wdata = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst mem_en", 32'(mem_en), 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_be", 32'(mem_be), 32'd0);
        check("rst m_done", 32'(m_done), 32'd0);
        check("rst d_done", 32'(d_done), 32'd0);
        check("rst m_rdata", m_rdata, 32'd0);
        check("rst d_rdata", d_rdata, 32'd0);
        check("rst m_stall", 32'(m_stall), 32'd0);

        xact(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, 32'h1234_5678, "m_load");
        xact(1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'b0011, 32'h1234_5678, "m_store");
        xact(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 32'h0000_BEEF, "d_read");

        // Simultaneous requests: M first, D once M has dropped its request.
        m_req = 1; m_we = 0; m_addr = 32'h10; m_be = 4'hF;
        d_req = 1; d_we = 0; d_addr = 32'h20;
        sb_q.push_back({1'b0, 32'h1234_5678});
        sb_q.push_back({1'b1, 32'h0000_BEEF});
        for (c = 0; c < 12; c++) begin
            if (c == 5)  m_req = 1'b0;
            if (c == 10) d_req = 1'b0;
            #1;
            check("both m_done", 32'(m_done), 32'(c == 4));
            check("both d_done", 32'(d_done), 32'(c == 9));
            check("both mem_en", 32'(mem_en), 32'(c == 1 || c == 6));
            if (m_done || d_done) begin
                e = sb_q.pop_front();
                check("both owner", 32'(d_done), 32'(e[32]));
                check("both rdata", d_done ? d_rdata : m_rdata, e[31:0]);
            end
            tick();
        end

        // Starvation: M held continuously, D waiting.
        m_req = 1; m_addr = 32'h10;
        d_req = 1; d_addr = 32'h20;
        for (int k = 0; k < 4; k++) sb_q.push_back({1'b0, 32'h1234_5678});
        sb_q.push_back({1'b1, 32'h0000_BEEF});
        sb_q.push_back({1'b0, 32'h1234_5678});
        n = 0;
        c = 0;
        while (n < 6 && c < 60) begin
            #1;
            if (m_done || d_done) begin
                e = sb_q.pop_front();
                n++;
                check("starve owner", 32'(d_done), 32'(e[32]));
                check("starve rdata", d_done ? d_rdata : m_rdata, e[31:0]);
                if (m_done && n == 4) check("starve at max", 32'(dut.u_arb.starve_q), SMAX);
                if (d_done) check("starve cleared", 32'(dut.u_arb.starve_q), 32'd0);
            end
            tick();
            c++;
        end
        check("starve all done", 32'(n), 32'd6);
        m_req = 1'b0;
        d_req = 1'b0;

        // Reset while an M load sits in WAIT.
        m_req = 1; m_we = 0; m_addr = 32'h10;
        tick();
        tick();
        reset = 1'b1;
        m_req = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("rstw state", 32'(dut.state_q), 32'd0);
        check("rstw mem_en", 32'(mem_en), 32'd0);
        check("rstw mem_addr", mem_addr, 32'd0);
        check("rstw m_rdata", m_rdata, 32'd0);
        check("rstw d_rdata", d_rdata, 32'd0);
        check("rstw m_stall", 32'(m_stall), 32'd0);
        for (int k = 0; k < 5; k++) begin
            check("rstw no m_done", 32'(m_done), 32'd0);
            tick();
            #1;
        end
        xact(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, 32'h1234_5678, "m_after_rst");

        xact1(1'b1, 32'h40, 32'hCAFE_F00D, 32'h0, "lat1 d_write");
        xact1(1'b0, 32'h40, 32'h0, 32'hCAFE_F00D, "lat1 d_read");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
